// File: rtl/pulse_capture.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : pulse_capture                                                   |
// | Purpose  : Detects rising edges on pulse_in and stores the free-running    |
// |            cycle timestamp of each edge in a show-ahead FIFO. Level,       |
// |            sticky overflow, dropped-edge counter and a registered irq are  |
// |            exposed for firmware.                                           |
// | Options  : PULSE_CAPTURE_DROP_CNT_EN - when defined, drop_cnt is an 8-bit  |
// |            saturating count of dropped edges; otherwise it is tied to 0.   |
// | Revision : 1.0 - initial release                                           |
// +---------------------------------------------------------------------------+
module pulse_capture #(
  parameter int TS_W       = 32,
  parameter int DEPTH      = 8,
  parameter int IRQ_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pulse_in,
  input  logic                       clear,
  input  logic                       rd_en,
  output logic [TS_W-1:0]            rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  output logic                       irq
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              PW       = AW + 1;
  localparam logic [PW-1:0]   THRESH_L = PW'(IRQ_THRESH);

  logic [TS_W-1:0] ts_q, ts_d;
  logic            pulse_prev_q;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic            irq_q, irq_d;
  logic [TS_W-1:0] mem_q [DEPTH];

  logic            edge_det;
  logic            empty;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;
  logic [PW-1:0]   level_w;

  // Occupancy decode and push/pop/drop qualification; clear overrides both sides.
  always_comb begin
    edge_det = pulse_in & ~pulse_prev_q;
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    level_w  = wr_ptr_q - rd_ptr_q;
    pop      = rd_en & ~empty & ~clear;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the edge.
    push     = edge_det & (~full | pop) & ~clear;
    drop     = edge_det & full & ~pop & ~clear;
  end

  // Next-state for timestamp, pointers, sticky overflow and irq.
  always_comb begin
    ts_d       = ts_q + 1'b1;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    irq_d      = (level_w >= THRESH_L) | overflow_q;
    if (clear) begin
      rd_ptr_d   = wr_ptr_q;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (drop) overflow_d = 1'b1;
    end
  end

  // Control and status registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q         <= '0;
      pulse_prev_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      ts_q         <= ts_d;
      pulse_prev_q <= pulse_in;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      irq_q        <= irq_d;
    end
  end

  // FIFO storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= ts_q;
  end

`ifdef PULSE_CAPTURE_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating dropped-edge counter.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clear) begin
      drop_cnt_d = 8'd0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= 8'd0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 8'd0;
`endif

  assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_valid = ~empty;
  assign level    = level_w;
  assign overflow = overflow_q;
  assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_capture.sv
`default_nettype none
// Testbench for pulse_capture: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model.
module tb_pulse_capture;

  localparam int TSW   = 8;
  localparam int DEP   = 8;
  localparam int THR   = 1;
  localparam int MASK  = (1 << TSW) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           pulse_in = 1'b0;
  logic           clear = 1'b0;
  logic           rd_en = 1'b0;
  logic [TSW-1:0] rd_data;
  logic           rd_valid;
  logic [3:0]     level;
  logic           overflow;
  logic [7:0]     drop_cnt;
  logic           irq;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  int unsigned ts_m;
  bit          prev_m;
  int          q_m[$];
  bit          ovf_m;
  int          drops_m;
  bit          irq_m;

  pulse_capture #(.TS_W(TSW), .DEPTH(DEP), .IRQ_THRESH(THR)) dut (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .clear(clear), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .level(level), .overflow(overflow),
    .drop_cnt(drop_cnt), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic int exp_drop();
`ifdef PULSE_CAPTURE_DROP_CNT_EN
    return drops_m;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    ts_m = 0; prev_m = 0; q_m.delete(); ovf_m = 0; drops_m = 0; irq_m = 0;
  endtask

  task automatic model_step(input bit p, input bit r, input bit c);
    bit irq_n, edge_d, popped;
    irq_n  = (q_m.size() >= THR) || ovf_m;
    edge_d = p && !prev_m;
    if (c) begin
      q_m.delete(); ovf_m = 0; drops_m = 0;
    end else begin
      popped = r && (q_m.size() > 0);
      if (popped) void'(q_m.pop_front());
      if (edge_d) begin
        if (q_m.size() == DEP) begin
          ovf_m = 1;
          if (drops_m < 255) drops_m++;
        end else begin
          q_m.push_back(int'(ts_m));
        end
      end
    end
    prev_m = p;
    ts_m   = (ts_m + 1) & MASK;
    irq_m  = irq_n;
  endtask

  task automatic tick(input bit p, input bit r, input bit c);
    pulse_in = p; rd_en = r; clear = c;
    @(posedge clk);
    model_step(p, r, c);
    #1;
  endtask

  task automatic do_reset();
    pulse_in = 0; rd_en = 0; clear = 0;
    #2 rst_n = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic advance_to(input int target);
    int n = 0;
    while (ts_m != target && n < 300) begin
      tick(0, 0, 0);
      n++;
    end
    vectors++;
    if (ts_m != target) begin
      errors++;
      $display("FAIL advance_to: ts model %0d, required %0d", ts_m, target);
    end
  endtask

  task automatic test_reset();
    pulse_in = 0; rd_en = 0; clear = 0;
    rst_n = 0;
    model_reset();
    #12;
    vectors += 5;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b, want 0", rd_valid); end
    if (level !== 4'd0)    begin errors++; $display("FAIL reset_level: got %0d, want 0", level); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, want 0", overflow); end
    if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d, want 0", drop_cnt); end
    if (irq !== 1'b0)      begin errors++; $display("FAIL reset_irq: got %b, want 0", irq); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic_capture();
    do_reset();
    for (int i = 0; i < 10; i++) tick(0, 0, 0);
    tick(1, 0, 0);
    vectors += 4;
    if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_rd_valid: got %b, want 1", rd_valid); end
    if (level !== 4'd1)    begin errors++; $display("FAIL basic_level: got %0d, want 1", level); end
    if (rd_data !== 8'd10) begin errors++; $display("FAIL basic_rd_data: got %0d, want 10", rd_data); end
    if (irq !== 1'b0)      begin errors++; $display("FAIL basic_irq_early: got %b, want 0", irq); end
    tick(0, 0, 0);
    vectors++;
    if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq: got %b, want 1", irq); end
    tick(0, 1, 0);
    vectors += 3;
    if (level !== 4'd0)    begin errors++; $display("FAIL basic_pop_level: got %0d, want 0", level); end
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_pop_valid: got %b, want 0", rd_valid); end
    if (irq !== 1'b1)      begin errors++; $display("FAIL basic_irq_hold: got %b, want 1", irq); end
    tick(0, 0, 0);
    vectors++;
    if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_drop: got %b, want 0", irq); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    advance_to(20);
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, 0);
      for (int j = 0; j < 3; j++) tick(0, 0, 0);
    end
    vectors += 3;
    if (level !== 4'd8)    begin errors++; $display("FAIL fill_level: got %0d, want 8", level); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow: got %b, want 1", overflow); end
`ifdef PULSE_CAPTURE_DROP_CNT_EN
    if (drop_cnt !== 8'd2) begin errors++; $display("FAIL fill_drop_cnt: got %0d, want 2", drop_cnt); end
`else
    if (drop_cnt !== 8'd0) begin errors++; $display("FAIL fill_drop_cnt: got %0d, want 0", drop_cnt); end
`endif
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (rd_data !== 8'(20 + 4 * i)) begin
        errors++; $display("FAIL fill_pop_data[%0d]: got %0d, want %0d", i, rd_data, 20 + 4 * i);
      end
      tick(0, 1, 0);
    end
    vectors += 2;
    if (level !== 4'd0)    begin errors++; $display("FAIL fill_drain_level: got %0d, want 0", level); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL fill_sticky_ovf: got %b, want 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    advance_to(20);
    for (int i = 0; i < 8; i++) begin
      tick(1, 0, 0);
      tick(0, 0, 0);
    end
    tick(1, 1, 0);
    vectors += 3;
    if (level !== 4'd8)    begin errors++; $display("FAIL pushpop_level: got %0d, want 8", level); end
    if (drop_cnt !== 8'd0) begin errors++; $display("FAIL pushpop_drop_cnt: got %0d, want 0", drop_cnt); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL pushpop_overflow: got %b, want 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (rd_data !== 8'(22 + 2 * i)) begin
        errors++; $display("FAIL pushpop_data[%0d]: got %0d, want %0d", i, rd_data, 22 + 2 * i);
      end
      tick(0, 1, 0);
    end
  endtask

  task automatic test_held_high();
    do_reset();
    advance_to(100);
    for (int i = 0; i < 5; i++) tick(1, 0, 0);
    tick(0, 0, 0);
    vectors += 2;
    if (level !== 4'd1)     begin errors++; $display("FAIL held_level: got %0d, want 1", level); end
    if (rd_data !== 8'd100) begin errors++; $display("FAIL held_data: got %0d, want 100", rd_data); end
  endtask

  task automatic test_clear_precedence();
    int t0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tick(1, 0, 0);
      tick(0, 0, 0);
    end
    for (int i = 0; i < 5; i++) tick(0, 1, 0);
    vectors += 2;
    if (level !== 4'd3)    begin errors++; $display("FAIL clr_pre_level: got %0d, want 3", level); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL clr_pre_ovf: got %b, want 1", overflow); end
    t0 = int'(ts_m);
    tick(1, 1, 1);
    vectors += 5;
    if (level !== 4'd0)    begin errors++; $display("FAIL clr_level: got %0d, want 0", level); end
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b, want 0", rd_valid); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow: got %b, want 0", overflow); end
    if (drop_cnt !== 8'd0) begin errors++; $display("FAIL clr_drop_cnt: got %0d, want 0", drop_cnt); end
    if (irq !== 1'b1)      begin errors++; $display("FAIL clr_irq_hold: got %b, want 1", irq); end
    tick(0, 0, 0);
    vectors++;
    if (irq !== 1'b0) begin errors++; $display("FAIL clr_irq: got %b, want 0", irq); end
    tick(0, 0, 0);
    tick(1, 0, 0);
    vectors++;
    if (rd_data !== 8'((t0 + 3) & MASK)) begin
      errors++; $display("FAIL clr_ts_running: got %0d, want %0d", rd_data, (t0 + 3) & MASK);
    end
  endtask

  task automatic test_wrap_async_reset();
    do_reset();
    advance_to(255);
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(1, 0, 0);
    vectors += 2;
    if (level !== 4'd2)     begin errors++; $display("FAIL wrap_level: got %0d, want 2", level); end
    if (rd_data !== 8'd255) begin errors++; $display("FAIL wrap_first: got %0d, want 255", rd_data); end
    tick(0, 1, 0);
    vectors += 2;
    if (rd_data !== 8'd1) begin errors++; $display("FAIL wrap_second: got %0d, want 1", rd_data); end
    if (irq !== 1'b1)     begin errors++; $display("FAIL wrap_irq: got %b, want 1", irq); end
    #2 rst_n = 0;
    #1;
    vectors += 3;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b, want 0", rd_valid); end
    if (level !== 4'd0)    begin errors++; $display("FAIL async_level: got %0d, want 0", level); end
    if (irq !== 1'b0)      begin errors++; $display("FAIL async_irq: got %b, want 0", irq); end
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_random();
    bit p, r, c;
    int rd_pct;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rd_pct = (i < 300) ? 10 : 55;
      p = ($urandom_range(99) < 45);
      r = ($urandom_range(99) < rd_pct);
      c = ($urandom_range(99) < 2);
      tick(p, r, c);
      vectors++;
      if (rd_valid !== (q_m.size() > 0) || level !== 4'(q_m.size()) ||
          overflow !== ovf_m || drop_cnt !== 8'(exp_drop()) || irq !== irq_m) begin
        errors++;
        $display("FAIL rand_status[%0d]: got v=%b l=%0d o=%b d=%0d i=%b, want v=%b l=%0d o=%b d=%0d i=%b",
                 i, rd_valid, level, overflow, drop_cnt, irq,
                 q_m.size() > 0, q_m.size(), ovf_m, exp_drop(), irq_m);
      end
      if (q_m.size() > 0) begin
        vectors++;
        if (rd_data !== 8'(q_m[0])) begin
          errors++; $display("FAIL rand_data[%0d]: got %0d, want %0d", i, rd_data, q_m[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_fill_overflow();
    test_full_push_pop();
    test_held_high();
    test_clear_precedence();
    test_wrap_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
